// File: rtl/output_port_arbiter.sv
// Round-robin, packet-locking arbiter for one router output port.
// Holds the crossbar select for a whole wormhole packet and force-releases overlong packets.
module output_port_arbiter #(
  parameter int unsigned N         = 5,
  parameter int unsigned MAX_FLITS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] valid,
  input  logic [N-1:0] tail,
  input  logic         out_ready,
  output logic [N-1:0] select,
  output logic [N-1:0] pop,
  output logic         out_valid,
  output logic         locked,
  output logic         err
);

  localparam int unsigned     CNT_W    = $clog2(MAX_FLITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_FLITS - 1);
  localparam logic [N-1:0]     PTR_RST  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e           state_q;
  logic [N-1:0]     select_q;
  logic [N-1:0]     ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic [N-1:0] masked_req;
  logic [N-1:0] winner_d;
  logic [N-1:0] ptr_d;
  logic         xfer;
  logic         tail_sel;

  // Bits at or above the one-hot pointer take priority; otherwise wrap to the lowest request.
  always_comb begin
    masked_req = req & ~(ptr_q - PTR_RST);
    if (masked_req != '0) begin
      winner_d = masked_req & (~masked_req + PTR_RST);
    end else begin
      winner_d = req & (~req + PTR_RST);
    end
  end

  assign pop       = select_q & valid & {N{out_ready}};
  assign xfer      = |pop;
  assign tail_sel  = |(select_q & tail);
  assign ptr_d     = {select_q[N-2:0], select_q[N-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      select_q <= '0;
      ptr_q    <= PTR_RST;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req != '0) begin
            select_q <= winner_d;
            state_q  <= LOCK;
            cnt_q    <= '0;
          end
        end
        LOCK: begin
          if (xfer) begin
            if (tail_sel || (cnt_q == CNT_LAST)) begin
              state_q  <= IDLE;
              select_q <= '0;
              ptr_q    <= ptr_d;
              cnt_q    <= '0;
              if (!tail_sel) begin
                err_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          select_q <= '0;
        end
      endcase
    end
  end

  assign select    = select_q;
  assign out_valid = xfer;
  assign locked    = (state_q == LOCK);
  assign err       = err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: vector table, directed corner sequences,
// and random traffic against an index-based packet-level reference model.
module tb_output_port_arbiter;

  localparam int N    = 5;
  localparam int MAXF = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] valid = '0;
  logic [N-1:0] tail = '0;
  logic         out_ready = 1'b0;
  logic [N-1:0] select;
  logic [N-1:0] pop;
  logic         out_valid;
  logic         locked;
  logic         err;

  always #5 clk = ~clk;

  output_port_arbiter #(.N(N), .MAX_FLITS(MAXF)) dut (
    .clk(clk), .rst(rst), .req(req), .valid(valid), .tail(tail),
    .out_ready(out_ready), .select(select), .pop(pop),
    .out_valid(out_valid), .locked(locked), .err(err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: owner index (-1 = idle), priority index, flits moved, sticky error.
  int owner   = -1;
  int prio    = 0;
  int moved   = 0;
  bit m_err   = 1'b0;
  bit m_known = 1'b0;

  logic [N-1:0] cap_sel, cap_pop;
  logic         cap_lk, cap_err, cap_ov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] v,
                      input logic [N-1:0] t, input logic rd);
    logic [N-1:0] e_sel, e_pop;
    rst = r; req = rq; valid = v; tail = t; out_ready = rd;
    e_sel = (owner >= 0) ? onehot(owner) : '0;
    e_pop = e_sel & v & {N{rd}};
    @(negedge clk);
    cap_sel = select; cap_pop = pop; cap_lk = locked; cap_err = err; cap_ov = out_valid;
    if (m_known) begin
      check("model_select", 32'(cap_sel), 32'(e_sel));
      check("model_pop", 32'(cap_pop), 32'(e_pop));
      check("model_out_valid", 32'(cap_ov), 32'(e_pop != '0));
      check("model_locked", 32'(cap_lk), 32'(owner >= 0));
      check("model_err", 32'(cap_err), 32'(m_err));
    end
    @(posedge clk);
    if (r) begin
      m_known = 1'b1; owner = -1; prio = 0; moved = 0; m_err = 1'b0;
    end else if (m_known) begin
      if (owner < 0) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (prio + k) % N;
          if (owner < 0 && ((rq >> idx) & 1) != 0) owner = idx;
        end
        moved = 0;
      end else if (e_pop != '0) begin
        moved++;
        if (((t >> owner) & 1) != 0 || moved == MAXF) begin
          if (((t >> owner) & 1) == 0) m_err = 1'b1;
          prio  = (owner + 1) % N;
          owner = -1;
          moved = 0;
        end
      end
    end
    #1;
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] rq, v, t;
    logic         rd;
    logic         chk;
    logic [N-1:0] esel, epop;
    logic         elk, eerr;
  } vec_t;

  vec_t tbl[10];
  int   npops;

  initial begin
    @(posedge clk);
    #1;

    // Reset, first arbitration, single-flit packets and the one-dead-cycle gap
    tbl[0] = '{1'b1, N'($urandom), N'($urandom), N'($urandom), 1'($urandom), 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, N'($urandom), N'($urandom), N'($urandom), 1'($urandom), 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 5'b11111, 5'b00000, 5'b00000, 1'b1, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b1, 5'b00001, 5'b00000, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 5'b00000, 5'b00001, 5'b00001, 1'b1, 1'b1, 5'b00001, 5'b00001, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 5'b00100, 5'b00100, 5'b00100, 1'b1, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 5'b00100, 5'b00100, 5'b00100, 1'b1, 1'b1, 5'b00100, 5'b00100, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 5'b00100, 5'b00100, 5'b00100, 1'b1, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 5'b00100, 5'b00100, 5'b00100, 1'b1, 1'b1, 5'b00100, 5'b00100, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].rq, tbl[i].v, tbl[i].t, tbl[i].rd);
      if (tbl[i].chk) begin
        check("tbl_select", 32'(cap_sel), 32'(tbl[i].esel));
        check("tbl_pop", 32'(cap_pop), 32'(tbl[i].epop));
        check("tbl_locked", 32'(cap_lk), 32'(tbl[i].elk));
        check("tbl_err", 32'(cap_err), 32'(tbl[i].eerr));
      end
    end

    // Round-robin order with 3-flit packets, no stalls
    step(1'b1, '0, '0, '0, 1'b1);
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) begin
          step(1'b0, '1, '1, '0, 1'b1);
          check("rr_dead_cycle", 32'(cap_sel), 32'(0));
        end else begin
          step(1'b0, '1, '1, (c == 3) ? '1 : '0, 1'b1);
          check("rr_select", 32'(cap_sel), 32'(onehot(p % N)));
          check("rr_pop", 32'(cap_pop), 32'(onehot(p % N)));
        end
      end
    end

    // Backpressure and valid gap on a 4-flit packet from input 3
    step(1'b1, '0, '0, '0, 1'b1);
    step(1'b0, 5'b01000, '0, '0, 1'b1);
    npops = 0;
    begin
      logic [7:0] bv, br, bt;
      bv = 8'b1101_1111;  // bit i = cycle i
      br = 8'b1111_0001;
      bt = 8'b1000_0000;
      for (int i = 0; i < 8; i++) begin
        step(1'b0, '0, bv[i] ? 5'b01000 : 5'b00000, bt[i] ? 5'b01000 : 5'b00000, br[i]);
        check("bp_select", 32'(cap_sel), 32'(5'b01000));
        check("bp_pop", 32'(cap_pop), 32'((bv[i] && br[i]) ? 5'b01000 : 5'b00000));
        if (cap_pop != '0) npops++;
      end
    end
    step(1'b0, '0, '0, '0, 1'b1);
    check("bp_released", 32'(cap_sel), 32'(0));
    check("bp_pop_count", 32'(npops), 32'(4));

    // Timeout: input 1 streams without tail
    step(1'b1, '0, '0, '0, 1'b1);
    step(1'b0, 5'b00010, '0, '0, 1'b1);
    for (int i = 0; i < MAXF; i++) begin
      step(1'b0, '0, 5'b00010, '0, 1'b1);
      check("to_pop", 32'(cap_pop), 32'(5'b00010));
      check("to_err_low", 32'(cap_err), 32'(0));
    end
    step(1'b0, '1, 5'b00010, '0, 1'b1);
    check("to_released", 32'(cap_sel), 32'(0));
    check("to_err_set", 32'(cap_err), 32'(1));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 5'b00010, '0, 1'b1);
      if (i == 0) check("to_next_grant", 32'(cap_sel), 32'(5'b00100));
      check("to_err_sticky", 32'(cap_err), 32'(1));
    end

    // Reset mid-packet from input 4
    step(1'b1, '0, '0, '0, 1'b1);
    step(1'b0, 5'b10000, '0, '0, 1'b1);
    step(1'b0, '0, 5'b10000, '0, 1'b1);
    step(1'b0, '0, 5'b10000, '0, 1'b1);
    step(1'b1, '0, 5'b10000, '0, 1'b1);
    step(1'b0, 5'b10001, 5'b10000, '0, 1'b1);
    check("rm_select", 32'(cap_sel), 32'(0));
    check("rm_locked", 32'(cap_lk), 32'(0));
    step(1'b0, '0, '0, '0, 1'b1);
    check("rm_grant", 32'(cap_sel), 32'(5'b00001));

    // Random traffic against the reference model
    step(1'b1, '0, '0, '0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      logic         r, rd;
      logic [N-1:0] rq, v, t;
      r  = ($urandom % 97) == 0;
      rq = N'($urandom);
      v  = N'($urandom) | N'($urandom);
      t  = (i < 1500) ? (N'($urandom) & N'($urandom)) : ((($urandom % 24) == 0) ? '1 : '0);
      rd = ($urandom % 4) != 0;
      step(r, rq, v, t, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
